// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 load/store codes,
// FSM states and access-size helpers.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    function automatic size_t size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // Low address bits with the sub-size offset cleared (natural alignment).
    function automatic logic [1:0] align_lo(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return lo;
            SZ_H:    return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Lane logic: byte enables, replicated store data and sign/zero-extended
// load data for one naturally aligned access.
module mem_access_unit_lsu_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data
);

    size_t       sz;
    logic        uns;
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    always_comb begin
        sz         = size_of(funct3);
        uns        = (funct3 == F3_BU) || (funct3 == F3_HU);
        byte_l     = rdata[{lo, 3'b000} +: 8];
        half_l     = rdata[{lo[1], 4'b0000} +: 16];
        be         = 4'b1111;
        store_data = wdata;
        load_data  = rdata;
        unique case (sz)
            SZ_B: begin
                be         = 4'b0001 << lo;
                store_data = {(XLEN/8){wdata[7:0]}};
                load_data  = {{(XLEN-8){~uns & byte_l[7]}}, byte_l};
            end
            SZ_H: begin
                be         = 4'b0011 << {lo[1], 1'b0};
                store_data = {(XLEN/16){wdata[15:0]}};
                load_data  = {{(XLEN-16){~uns & half_l[15]}}, half_l};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine (IDLE -> ACCESS -> RESP).
// Define MEM_MISALIGN_TRAP_EN to trap misaligned h/w accesses instead of aligning them.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    output logic            stall_o,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            bus_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    state_t          state, state_next;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            we_q, rw_q;
    logic [CW-1:0]   cnt, cnt_inc;
    logic            memop, accept, misalign, timeout;
    logic [1:0]      lo_in;
    logic [3:0]      be;
    logic [XLEN-1:0] lane_wdata, load_data;

    assign memop   = in_mem_read | in_mem_write;
    assign accept  = (state == ST_IDLE) && in_valid && memop;
    assign lo_in   = align_lo(size_of(in_funct3), in_addr[1:0]);
    assign cnt_inc = cnt + 1'b1;
    assign timeout = (TIMEOUT_CYCLES != 0) && !dmem_ready
                     && (cnt_inc == CW'(TIMEOUT_CYCLES));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (lo_in != in_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    mem_access_unit_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (f3_q),
        .lo         (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (dmem_rdata),
        .be         (be),
        .store_data (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (accept) state_next = misalign ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (dmem_ready || timeout) state_next = ST_RESP;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o    = accept || (state == ST_ACCESS);
        dmem_req   = (state == ST_ACCESS);
        dmem_we    = dmem_req & we_q;
        dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        dmem_be    = dmem_req ? be : 4'b0000;
        dmem_wdata = dmem_req ? lane_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            rw_q         <= 1'b0;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            bus_err_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid && !memop) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= in_rd;
                        wb_reg_write <= in_reg_write;
                        wb_data      <= in_addr;
                    end else if (accept) begin
                        addr_q  <= {in_addr[XLEN-1:2], lo_in};
                        wdata_q <= in_wdata;
                        f3_q    <= in_funct3;
                        rd_q    <= in_rd;
                        we_q    <= in_mem_write & ~in_mem_read;
                        rw_q    <= in_reg_write;
                        cnt     <= '0;
                        if (misalign) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= in_rd;
                            wb_reg_write <= 1'b0;
                            wb_data      <= '0;
                            bus_err_o    <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt_inc;
                    if (dmem_ready) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_reg_write <= rw_q & ~we_q;
                        wb_data      <= we_q ? '0 : load_data;
                    end else if (timeout) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_reg_write <= 1'b0;
                        wb_data      <= '0;
                        bus_err_o    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
